// File: rtl/simd_sequencer_pkg.sv
// simd_sequencer_pkg: shared opcode, width and FSM state definitions
// for the SIMD issue sequencer and its hazard scoreboard.
package simd_sequencer_pkg;

  localparam int OPCODE_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OPC_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/simd_sequencer_if.sv
// simd_sequencer_if: operand bus of the fetched instruction.
// Ports: a_addr/b_addr sources, r_addr destination, wen result write.
interface simd_sequencer_if #(
  parameter int ADDR_WIDTH = 10
) ();

  logic [ADDR_WIDTH-1:0] a_addr;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  wen;

  modport master (
    output a_addr,
    output b_addr,
    output r_addr,
    output wen
  );

  modport slave (
    input a_addr,
    input b_addr,
    input r_addr,
    input wen
  );

endinterface

// File: rtl/simd_sequencer_hazard.sv
// hazard_scoreboard: 2-entry {valid,wen,r_addr} history of issue slots.
// Ports: i_clr flush, i_push shift, i_issue real op, ins bus, o_hazard RAW.
module hazard_scoreboard
  import simd_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic              i_issue,
  simd_sequencer_if.slave   ins,
  output logic              o_hazard
);

  logic [1:0]            r_vld;
  logic [1:0]            r_wen;
  logic [ADDR_WIDTH-1:0] r_dst [2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld    <= '0;
      r_wen    <= '0;
      r_dst[0] <= '0;
      r_dst[1] <= '0;
    end else if (i_clr) begin
      r_vld    <= '0;
      r_wen    <= '0;
      r_dst[0] <= '0;
      r_dst[1] <= '0;
    end else if (i_push) begin
      // Non-issue slots shift in an all-zero bubble.
      r_vld    <= {r_vld[0], i_issue};
      r_wen    <= {r_wen[0], i_issue & ins.wen};
      r_dst[1] <= r_dst[0];
      r_dst[0] <= i_issue ? ins.r_addr : '0;
    end
  end

  always_comb begin
    o_hazard = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (r_vld[i] && r_wen[i] &&
          (ins.a_addr == r_dst[i] ||
           ins.b_addr == r_dst[i]))
        o_hazard = 1'b1;
    end
  end

endmodule

// File: rtl/simd_sequencer.sv
// simd_sequencer: half-rate issue FSM with RAW stalls and HALT drain.
// Ports: start/start_pc run request, ins_* fetched op, pc fetch address,
// stall/step datapath control, busy/done/err status.
module simd_sequencer
  import simd_sequencer_pkg::*;
#(
  parameter int INS_ADDR_WIDTH = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int OPCODE_WIDTH   = simd_sequencer_pkg::OPCODE_WIDTH,
  parameter int DRAIN_STEPS    = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [INS_ADDR_WIDTH-1:0] start_pc,
  input  logic [OPCODE_WIDTH-1:0]   ins_opcode,
  input  logic [ADDR_WIDTH-1:0]     ins_a_addr,
  input  logic [ADDR_WIDTH-1:0]     ins_b_addr,
  input  logic [ADDR_WIDTH-1:0]     ins_r_addr,
  input  logic                      ins_wen,
  output logic [INS_ADDR_WIDTH-1:0] pc,
  output logic                      stall,
  output logic                      step,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int CW =
    (DRAIN_STEPS > 1) ? $clog2(DRAIN_STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DRAIN_STEPS - 1);
  localparam logic [OPCODE_WIDTH-1:0] LP_HALT =
    OPCODE_WIDTH'(OPC_HALT);

  state_t                    r_state;
  logic                      r_phase;
  logic [INS_ADDR_WIDTH-1:0] r_pc;
  logic [CW-1:0]             r_cnt;
  logic                      r_stall;
  logic                      r_step;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_err;

  logic w_hazard;
  logic w_halt;
  logic w_issue;
  logic w_push;
  logic w_clr;

  simd_sequencer_if #(.ADDR_WIDTH(ADDR_WIDTH)) u_ins ();

  assign u_ins.a_addr = ins_a_addr;
  assign u_ins.b_addr = ins_b_addr;
  assign u_ins.r_addr = ins_r_addr;
  assign u_ins.wen    = ins_wen;

  // HALT wins over a hazard: it never reaches the datapath.
  assign w_halt  = (ins_opcode == LP_HALT);
  assign w_issue = (r_state == S_RUN) & r_phase &
                   ~w_halt & ~w_hazard;
  assign w_push  = r_phase &
                   ((r_state == S_RUN) | (r_state == S_DRAIN));
  assign w_clr   = (r_state == S_IDLE) & start;

  hazard_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk      (clk),
    .rstn     (rstn),
    .i_clr    (w_clr),
    .i_push   (w_push),
    .i_issue  (w_issue),
    .ins      (u_ins),
    .o_hazard (w_hazard)
  );

  // Slot decisions happen on edges with r_phase=1; stall/step
  // then cover the following half-rate datapath cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_phase <= 1'b0;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_stall <= 1'b0;
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
      r_step  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc    <= start_pc;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_RUN;
        S_RUN: begin
          if (r_phase) begin
            if (w_halt) begin
              r_stall <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_DRAIN;
            end else if (w_hazard) begin
              r_stall <= 1'b1;
            end else begin
              r_stall <= 1'b0;
              r_step  <= 1'b1;
              // Last address: issue, flag, never wrap.
              if (&r_pc) begin
                r_err   <= 1'b1;
                r_cnt   <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_pc <= r_pc + INS_ADDR_WIDTH'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          if (r_phase) begin
            if (r_cnt == LAST) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pc    = r_pc;
  assign stall = r_stall;
  assign step  = r_step;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;

endmodule
